// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the handshaked ALU: opcode map, opcode category
// ranges, FSM state encoding, flag bundle and the flag-derivation helper.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

   // Opcode map
   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_MUL    = 4'b0010;
   localparam logic [3:0] OP_DIV    = 4'b0011;
   localparam logic [3:0] OP_AND    = 4'b0100;
   localparam logic [3:0] OP_OR     = 4'b0101;
   localparam logic [3:0] OP_NAND   = 4'b0110;
   localparam logic [3:0] OP_NOR    = 4'b0111;
   localparam logic [3:0] OP_XOR    = 4'b1000;
   localparam logic [3:0] OP_XNOR   = 4'b1001;
   localparam logic [3:0] OP_CMP_EQ = 4'b1010;
   localparam logic [3:0] OP_CMP_GT = 4'b1011;
   localparam logic [3:0] OP_CMP_LT = 4'b1100;
   localparam logic [3:0] OP_SHR    = 4'b1101;
   localparam logic [3:0] OP_SHL    = 4'b1110;
   localparam logic [3:0] OP_NOP    = 4'b1111;

   // Category ranges (inclusive)
   localparam logic [3:0] ARITH_FIRST = OP_ADD;
   localparam logic [3:0] ARITH_LAST  = OP_DIV;
   localparam logic [3:0] LOGIC_FIRST = OP_AND;
   localparam logic [3:0] LOGIC_LAST  = OP_XNOR;
   localparam logic [3:0] CMP_FIRST   = OP_CMP_EQ;
   localparam logic [3:0] CMP_LAST    = OP_CMP_LT;
   localparam logic [3:0] SHIFT_FIRST = OP_SHR;
   localparam logic [3:0] SHIFT_LAST  = OP_SHL;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic arith;
      logic logic_op;
      logic cmp;
      logic shift;
      logic zero;
      logic div_zero;
   } flags_t;

   function automatic logic op_in(input logic [3:0] op, input logic [3:0] first,
                                  input logic [3:0] last);
      return (op >= first) && (op <= last);
   endfunction

   // carry must already be zero for anything other than ADD/SUB.
   function automatic flags_t make_flags(input logic [3:0] op, input logic carry,
                                         input logic res_zero, input logic b_zero);
      flags_t f;
      f.carry    = carry;
      f.arith    = op_in(op, ARITH_FIRST, ARITH_LAST);
      f.logic_op = op_in(op, LOGIC_FIRST, LOGIC_LAST);
      f.cmp      = op_in(op, CMP_FIRST, CMP_LAST);
      f.shift    = op_in(op, SHIFT_FIRST, SHIFT_LAST);
      f.zero     = res_zero && (op != OP_NOP);
      f.div_zero = (op == OP_DIV) && b_zero;
      return f;
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if
// Issue/writeback bus of the ALU.
//   master : issuer/consumer side (drives IN_VALID, A, B, ALU_FUN, OUT_READY)
//   slave  : ALU side (drives IN_READY, OUT_VALID, results and flags)
// -----------------------------------------------------------------------------
interface alu_pipe_if #(parameter int WIDTH = 16);

   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_FUN;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] ALU_OUT;
   logic [WIDTH-1:0] ALU_OUT_HI;
   logic             Carry_Flag;
   logic             Arith_Flag;
   logic             Logic_Flag;
   logic             CMP_Flag;
   logic             Shift_Flag;
   logic             Zero_Flag;
   logic             DivZero_Flag;

   modport master (
      output IN_VALID, A, B, ALU_FUN, OUT_READY,
      input  IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI,
             Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
             Zero_Flag, DivZero_Flag
   );

   modport slave (
      input  IN_VALID, A, B, ALU_FUN, OUT_READY,
      output IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI,
             Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
             Zero_Flag, DivZero_Flag
   );

endinterface

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative unsigned shift-add multiplier / restoring divider, one step per
// cycle, WIDTH steps per operation.
//   CLK, RST       clock, synchronous active-low reset
//   start          load operands and begin (ignored unless the caller is idle)
//   div_sel        1 = divide op_a by op_b, 0 = multiply
//   op_a, op_b     operands
//   done           high during the cycle the final step is taken
//   res_lo/res_hi  product {hi,lo} or quotient/remainder; valid while done
// -----------------------------------------------------------------------------
module alu_muldiv_iter #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             div_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CW = $clog2(WIDTH);

   logic             busy_q;
   logic             is_div_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;   // product accumulator / remainder:quotient
   logic [WIDTH-1:0] m_q;          // multiplicand or divisor
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [WIDTH:0]   sum, shifted, diff;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier bit is set,
      // then shift the whole {carry,hi,lo} right by one.
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      // Divide: shift the next dividend bit into the remainder and try a
      // subtraction; a borrow (MSB set) means restore.
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, m_q};
      if (is_div_q) begin
         if (diff[WIDTH]) begin
            hi_d = shifted[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end else begin
            hi_d = diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // The final step's values go straight to the caller, which registers them,
   // so a WIDTH-step operation occupies exactly WIDTH cycles after start.
   assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign res_lo = lo_d;
   assign res_hi = hi_d;

   // NOTE: state is updated with <= so every flop samples pre-edge values;
   // reset is synchronous, so it lives inside the clocked branch.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         busy_q   <= 1'b0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         m_q      <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         is_div_q <= div_sel;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= div_sel ? op_a : op_b;
         m_q      <= div_sel ? op_b : op_a;
      end else if (busy_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + CW'(1);
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU with registered result and category flags. Single-cycle ops
// complete on the acceptance edge; MUL and DIV (B!=0) iterate for WIDTH cycles.
//   CLK   rising-edge clock
//   RST   synchronous active-low reset
//   bus   alu_pipe_if.slave: IN_VALID/IN_READY, A, B, ALU_FUN in;
//         OUT_VALID/OUT_READY, ALU_OUT, ALU_OUT_HI and the seven flags out
// -----------------------------------------------------------------------------
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic     CLK,
   input  logic     RST,
   alu_pipe_if.slave bus
);

   state_e           state_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] alu_out_q, alu_out_hi_q;
   flags_t           flags_q;

   logic             in_ready, accept, b_zero, iter_op, it_done;
   logic [WIDTH-1:0] it_lo, it_hi;
   logic [WIDTH-1:0] sc_lo, sc_hi;
   logic             sc_carry;
   flags_t           sc_flags;

   // In DONE a new op may only enter when the held result is taken this cycle.
   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.OUT_READY);
   assign accept   = bus.IN_VALID && in_ready;
   assign b_zero   = (bus.B == '0);
   assign iter_op  = (bus.ALU_FUN == OP_MUL) || ((bus.ALU_FUN == OP_DIV) && !b_zero);

   // Single-cycle datapath. DIV lands here only for B==0.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      sc_lo    = '0;
      sc_hi    = '0;
      sc_carry = 1'b0;
      case (bus.ALU_FUN)
         OP_ADD:    {sc_carry, sc_lo} = {1'b0, bus.A} + {1'b0, bus.B};
         OP_SUB: begin
            sc_lo    = bus.A - bus.B;
            sc_carry = bus.A < bus.B;
         end
         OP_DIV: begin
            sc_lo = '1;
            sc_hi = bus.A;
         end
         OP_AND:    sc_lo = bus.A & bus.B;
         OP_OR:     sc_lo = bus.A | bus.B;
         OP_NAND:   sc_lo = ~(bus.A & bus.B);
         OP_NOR:    sc_lo = ~(bus.A | bus.B);
         OP_XOR:    sc_lo = bus.A ^ bus.B;
         OP_XNOR:   sc_lo = ~(bus.A ^ bus.B);
         OP_CMP_EQ: sc_lo = {{(WIDTH-1){1'b0}}, bus.A == bus.B};
         OP_CMP_GT: sc_lo = {{(WIDTH-1){1'b0}}, bus.A >  bus.B};
         OP_CMP_LT: sc_lo = {{(WIDTH-1){1'b0}}, bus.A <  bus.B};
         OP_SHR:    sc_lo = bus.A >> 1;
         OP_SHL:    sc_lo = bus.A << 1;
         default:   ;
      endcase
      sc_flags = make_flags(bus.ALU_FUN, sc_carry, sc_lo == '0, b_zero);
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .CLK    (CLK),
      .RST    (RST),
      .start  (accept && iter_op),
      .div_sel(bus.ALU_FUN == OP_DIV),
      .op_a   (bus.A),
      .op_b   (bus.B),
      .done   (it_done),
      .res_lo (it_lo),
      .res_hi (it_hi)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         alu_out_q    <= '0;
         alu_out_hi_q <= '0;
         flags_q      <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (iter_op) begin
                     out_valid_q <= 1'b0;
                     state_q     <= ST_ITER;
                  end else begin
                     alu_out_q    <= sc_lo;
                     alu_out_hi_q <= sc_hi;
                     flags_q      <= sc_flags;
                     out_valid_q  <= 1'b1;
                     state_q      <= ST_DONE;
                  end
               end else if ((state_q == ST_DONE) && bus.OUT_READY) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            ST_ITER: begin
               if (it_done) begin
                  alu_out_q    <= it_lo;
                  alu_out_hi_q <= it_hi;
                  // MUL and iterating DIV share one flag pattern: arithmetic,
                  // no carry, no div-by-zero (B==0 never iterates).
                  flags_q      <= make_flags(OP_MUL, 1'b0, it_lo == '0, 1'b0);
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.IN_READY     = in_ready;
   assign bus.OUT_VALID    = out_valid_q;
   assign bus.ALU_OUT      = alu_out_q;
   assign bus.ALU_OUT_HI   = alu_out_hi_q;
   assign bus.Carry_Flag   = flags_q.carry;
   assign bus.Arith_Flag   = flags_q.arith;
   assign bus.Logic_Flag   = flags_q.logic_op;
   assign bus.CMP_Flag     = flags_q.cmp;
   assign bus.Shift_Flag   = flags_q.shift;
   assign bus.Zero_Flag    = flags_q.zero;
   assign bus.DivZero_Flag = flags_q.div_zero;

endmodule
